// File: rtl/biriscv_icache_flush_ctrl.sv
// ----------------------------------------------------------------------------
// biriscv_icache_flush_ctrl
// Instruction-cache maintenance controller. It sequences full-cache flushes
// (a walk over every line index) and single-line invalidates. While maintenance
// is pending or running it gates the fetch -> cache read path. Before it starts
// any walk it waits for an outstanding cache read to return.
//
// Ports
//   clk, rst_n          clock and asynchronous active-low reset
//   flush_req_i         full flush request pulse
//   inval_req_i         single-line invalidate pulse, addressed by inval_addr_i
//   fetch_rd_i/pc_i     fetch read request and address
//   fetch_accept_o      read accepted (cache accept passed through when open)
//   cache_rd_o/pc_o     read request and address forwarded to the cache array
//   cache_accept_i      cache array accepts cache_rd_o
//   cache_valid_i       cache array read response
//   line_inval_o/idx_o  invalidate strobe and line index
//   busy_o              maintenance pending or in progress
//   flush_done_o        one-cycle pulse when a full flush completes
// ----------------------------------------------------------------------------
module biriscv_icache_flush_ctrl #(
    parameter int unsigned NUM_LINES  = 256,
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned LINE_SHIFT = 5,
    parameter int unsigned INIT_FLUSH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_req_i,
    input  logic             inval_req_i,
    input  logic [31:0]      inval_addr_i,
    input  logic             fetch_rd_i,
    input  logic [31:0]      fetch_pc_i,
    output logic             fetch_accept_o,
    output logic             cache_rd_o,
    output logic [31:0]      cache_pc_o,
    input  logic             cache_accept_i,
    input  logic             cache_valid_i,
    output logic             line_inval_o,
    output logic [IDX_W-1:0] line_idx_o,
    output logic             busy_o,
    output logic             flush_done_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_INVAL,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_cnt;
    logic             r_outstanding;
    logic             r_flush_pend;
    logic             r_inval_pend;
    logic [IDX_W-1:0] r_inval_idx;

    logic w_inval_cap;
    logic w_flush_any;
    logic w_inval_any;
    logic w_wait_rsp;
    logic w_enter_flush;
    logic w_open;
    logic w_unused_addr;

    // An invalidate that coincides with a flush request is subsumed by the flush.
    assign w_inval_cap = inval_req_i && !flush_req_i;
    assign w_flush_any = flush_req_i || r_flush_pend;
    assign w_inval_any = w_inval_cap || r_inval_pend;

    // A read is in flight and its response has not arrived this cycle.
    assign w_wait_rsp  = r_outstanding && !cache_valid_i;

    // Every path into the FLUSH state.
    assign w_enter_flush = ((r_state == ST_IDLE)  && w_flush_any && !w_wait_rsp) ||
                           ((r_state == ST_DRAIN) && w_flush_any && cache_valid_i) ||
                           ((r_state == ST_DONE)  && r_flush_pend);

    // Fetch path is open only with no maintenance requested, pending or active.
    assign w_open = (r_state == ST_IDLE) && !r_flush_pend && !r_inval_pend &&
                    !flush_req_i && !inval_req_i;

    assign cache_rd_o     = w_open && fetch_rd_i;
    assign cache_pc_o     = fetch_pc_i;
    assign fetch_accept_o = w_open && cache_accept_i;

    // Maintenance outputs are pure decodes of state flops.
    assign line_inval_o = (r_state == ST_FLUSH) || (r_state == ST_INVAL);
    assign line_idx_o   = (r_state == ST_FLUSH) ? r_cnt :
                          (r_state == ST_INVAL) ? r_inval_idx : '0;
    assign flush_done_o = (r_state == ST_DONE);
    assign busy_o       = (r_state != ST_IDLE) || r_flush_pend || r_inval_pend;

    // Only the line-index field of the invalidate address is consumed.
    assign w_unused_addr = ^inval_addr_i;

    // Outstanding read tracker; a new accept wins over a same-cycle response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= 1'b0;
        end else if (cache_rd_o && cache_accept_i) begin
            r_outstanding <= 1'b1;
        end else if (cache_valid_i) begin
            r_outstanding <= 1'b0;
        end
    end

    // Pending request capture; entering a flush retires both kinds of request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_pend <= 1'(INIT_FLUSH != 0);
            r_inval_pend <= 1'b0;
            r_inval_idx  <= '0;
        end else begin
            if (w_enter_flush) begin
                r_flush_pend <= 1'b0;
            end else if (flush_req_i) begin
                r_flush_pend <= 1'b1;
            end

            if (w_inval_cap) begin
                r_inval_idx <= inval_addr_i[LINE_SHIFT+IDX_W-1:LINE_SHIFT];
            end

            if (w_enter_flush) begin
                r_inval_pend <= 1'b0;
            end else if (w_inval_cap) begin
                r_inval_pend <= 1'b1;
            end else if (r_state == ST_INVAL) begin
                r_inval_pend <= 1'b0;
            end
        end
    end

    // Maintenance sequencer and line-walk counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_flush_any || w_inval_any) begin
                        if (w_wait_rsp) begin
                            r_state <= ST_DRAIN;
                        end else if (w_flush_any) begin
                            r_state <= ST_FLUSH;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_INVAL;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cache_valid_i) begin
                        if (w_flush_any) begin
                            r_state <= ST_FLUSH;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_INVAL;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == LAST_IDX) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end
                ST_INVAL: begin
                    r_state <= ST_IDLE;
                end
                ST_DONE: begin
                    if (r_flush_pend) begin
                        r_state <= ST_FLUSH;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
